axis_seg7_display: RTL

AXI-Stream sink that accepts W-bit unsigned words (e.g. the running sums produced by the accumulator stage) and shows the most recent one in decimal on a multiplexed, common-anode 7-segment display. Each accepted word is converted to BCD by a sequential shift-add-3 (double-dabble) engine. The result is latched into a display register, and a scan counter time-multiplexes the digits. The block sits between the AXIS datapath and the board's segment/anode pins.

---
 rtl/axis_seg7_display.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axis_seg7_display.sv
// AXI-Stream sink that converts each accepted unsigned word to BCD (double-dabble)
// and shows it on a multiplexed, common-anode 7-segment display with leading-zero blanking.
module axis_seg7_display #(
  parameter int unsigned W        = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_data,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  if (pow10(DIGITS) <= ((64'd1 << W) - 64'd1)) begin : g_digits_check
    $error("axis_seg7_display: DIGITS too small to show 2^W-1");
  end

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   sh;
  logic [BW-1:0]  bcd, bcd_adj, disp;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  scan_cnt;
  logic [IW-1:0]  idx;
  logic [3:0]     sel_nib;
  logic           upper_nz, blank;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) state_nx = CONV;
      end
      CONV: if (cnt == CW'(W - 1)) state_nx = LOAD;
      LOAD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // {bcd, sh} is one shift register: the MSB of sh enters the BCD LSB each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      disp <= '0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          sh  <= s_data;
          bcd <= '0;
          cnt <= '0;
        end
        CONV: begin
          bcd <= {bcd_adj[BW-2:0], sh[W-1]};
          sh  <= {sh[W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        LOAD: disp <= bcd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    sel_nib  = disp[{idx, 2'b00} +: 4];
    upper_nz = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IW'(i) >= idx && disp[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
    blank = (idx != '0) && !upper_nz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'b1000000;
      an  <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      seg <= blank ? '1 : seg_dec(sel_nib);
      an  <= ~(DIGITS'(1) << idx);
    end
  end

endmodule
